ct_f_spsram_128x16_ctrl: RTL

//  Request-side controller that drives one 128x16 single-port FPGA SRAM macro
//  (A/CEN/GWEN/WEN/D in, Q out; active-low enables; 1-cycle read latency).

---
 rtl/ct_f_spsram_128x16_ctrl_if.sv | 29 ++
 rtl/ct_f_spsram_128x16_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_128x16_ctrl_if.sv
// Request/response bus of the 128x16 SRAM controller.
// The master issues read/write requests and consumes read responses.
interface ct_f_spsram_128x16_ctrl_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) ();

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;

  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );

endinterface

// File: rtl/ct_f_spsram_128x16_ctrl.sv
// Request-side controller for a 128x16 single-port SRAM macro.
// Clears the array after reset, then serves one read or write per cycle.
// Read data (1-cycle macro latency) lands in a small response FIFO and is
// returned in order; request credit covers FIFO entries plus in-flight reads,
// so the FIFO can never overflow.
module ct_f_spsram_128x16_ctrl #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    RSP_DEPTH  = 3,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  ct_f_spsram_128x16_ctrl_if.slave bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [RSP_DEPTH];

  logic                  req_rdy;
  logic                  req_acc;
  logic                  rd_acc;
  logic                  rsp_vld;
  logic                  push;
  logic                  pop;
  logic                  credit_ok;
  logic [CNT_W:0]        used_slots;

  // Wrap-around increment for a FIFO pointer (depth need not be a power of 2).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit and request handshake; depends only on registered state, RST and req_wr.
  always_comb begin
    used_slots = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, rd_inflight_q};
    credit_ok  = used_slots < (CNT_W + 1)'(RSP_DEPTH);
    req_rdy    = !RST && (state_q == ST_RUN) && (bus.req_wr || credit_ok);
    req_acc    = bus.req_vld && req_rdy;
    rd_acc     = req_acc && !bus.req_wr;
    rsp_vld    = (fifo_cnt_q != '0);
    push       = rd_inflight_q;
    pop        = rsp_vld && bus.rsp_rdy;
  end

  assign bus.req_rdy   = req_rdy;
  assign bus.rsp_vld   = rsp_vld;
  assign bus.rsp_rdata = rsp_vld ? fifo_mem_q[rd_ptr_q] : '0;
  assign init_done     = init_done_q;

  // SRAM pin drive: idle in reset, clear sweep in INIT, request pass-through in RUN.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    A    = '0;
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    D    = '0;
    if (!RST) begin
      if (state_q == ST_INIT) begin
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = '0;
        A    = cnt_q;
        D    = INIT_VAL;
      end else if (req_acc) begin
        CEN = 1'b0;
        A   = bus.req_addr;
        if (bus.req_wr) begin
          GWEN = 1'b0;
          WEN  = ~bus.req_wmask;
          D    = bus.req_wdata;
        end
      end
    end
  end

  // Next-state: sweep counter, FSM, read pipeline flag and response FIFO.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    fifo_mem_d    = fifo_mem_q;
    rd_inflight_d = rd_acc;

    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
    init_done_d = (state_d == ST_RUN);

    if (push) begin
      fifo_mem_d[wr_ptr_q] = Q;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control state registers with synchronous reset; reset drops all pending work.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) begin
      state_q       <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_q         <= '0;
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_done_q   <= init_done_d;
      rd_inflight_q <= rd_inflight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // Response FIFO storage.
  always_ff @(posedge CLK) begin
    // NOTE: data storage is not reset; the count gates every read, so stale words are never seen.
    fifo_mem_q <= fifo_mem_d;
  end

endmodule
